// File: rtl/cache_wb_assoc_if.sv
// CPU and physical-memory bus bundle for cache_wb_assoc.
// The master modport is the environment, which drives CPU requests and memory
// responses. The slave modport is the cache itself.
interface cache_wb_assoc_if #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 16,
    parameter int LINE_W = 128
);
    logic                  mem_read;
    logic                  mem_write;
    logic [WORD_W/8-1:0]   mem_byte_enable;
    logic [ADDR_W-1:0]     mem_address;
    logic [WORD_W-1:0]     mem_wdata;
    logic                  mem_resp;
    logic [WORD_W-1:0]     mem_rdata;
    logic                  pmem_resp;
    logic [LINE_W-1:0]     pmem_rdata;
    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_W-1:0]     pmem_address;
    logic [LINE_W-1:0]     pmem_wdata;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output pmem_resp, pmem_rdata,
        input  mem_resp, mem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  pmem_resp, pmem_rdata,
        output mem_resp, mem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cache_wb_assoc.sv
// Write-back, write-allocate, N-way set-associative cache.
// The CPU side is a word port with byte enables. The memory side moves one full
// line per transfer. Replacement takes the lowest invalid way first; when every
// way is valid it uses a per-set round-robin pointer.
// Optional feature macro: CACHE_PERF_CNT_EN adds the saturating hit_count and
// miss_count outputs.
module cache_wb_assoc #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 16,
    parameter int LINE_W = 128,
    parameter int SETS   = 8,
    parameter int WAYS   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    cache_wb_assoc_if.slave bus
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count
`endif
);
    localparam int BYTES = WORD_W / 8;
    localparam int OFF   = $clog2(LINE_W / 8);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG   = ADDR_W - IDX - OFF;
    localparam int BSEL  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WSEL  = OFF - BSEL;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        WB    = 2'd2,
        ALLOC = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;

    logic [LINE_W-1:0]  data_r  [WAYS][SETS];
    logic [TAG-1:0]     tag_r   [WAYS][SETS];
    logic [WAYS-1:0]    valid_r [SETS];
    logic [WAYS-1:0]    dirty_r [SETS];

    logic [WAY_W-1:0]   victim_r;
    logic               victim_rr_r;

    logic [TAG-1:0]     tag_s;
    logic [IDX-1:0]     idx_s;
    logic [WSEL-1:0]    word_s;
    logic               req_s;
    logic               is_write_s;
    logic               hit_s;
    logic [WAY_W-1:0]   hit_way_s;
    logic               inv_found_s;
    logic [WAY_W-1:0]   inv_way_s;
    logic [WAY_W-1:0]   rr_cur_s;
    logic [WAY_W-1:0]   victim_s;
    logic [LINE_W-1:0]  hit_line_s;
    logic [LINE_W-1:0]  merged_line_s;
    logic               hit_wr_en_s;
    logic               fill_en_s;
    logic               unused_addr_s;

    // Returns the old word with the enabled byte lanes replaced by new data.
    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [BYTES-1:0]  be
    );
        logic [WORD_W-1:0] res;
        res = old_w;
        for (int b = 0; b < BYTES; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_w[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_w[b*8 +: 8];
            end
        end
        return res;
    endfunction

    assign tag_s         = bus.mem_address[ADDR_W-1 -: TAG];
    assign idx_s         = bus.mem_address[OFF +: IDX];
    assign word_s        = bus.mem_address[OFF-1 : BSEL];
    assign unused_addr_s = ^bus.mem_address[BSEL-1:0];
    assign req_s         = bus.mem_read | bus.mem_write;
    // A simultaneous read and write request is treated as a read.
    assign is_write_s    = bus.mem_write & ~bus.mem_read;
    assign hit_wr_en_s   = (state_r == CHECK) && hit_s && is_write_s;
    assign fill_en_s     = (state_r == ALLOC) && bus.pmem_resp;

    // Tag compare across all ways of the addressed set; the lowest matching way wins.
    always_comb begin
        hit_s     = 1'b0;
        hit_way_s = {WAY_W{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_s && valid_r[idx_s][w] && (tag_r[w][idx_s] == tag_s)) begin
                hit_s     = 1'b1;
                hit_way_s = WAY_W'(w);
            end else begin
                hit_way_s = hit_way_s;
            end
        end
    end

    // Victim choice: the lowest invalid way, else the set's round-robin pointer.
    always_comb begin
        inv_found_s = 1'b0;
        inv_way_s   = {WAY_W{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            if (!inv_found_s && !valid_r[idx_s][w]) begin
                inv_found_s = 1'b1;
                inv_way_s   = WAY_W'(w);
            end else begin
                inv_way_s   = inv_way_s;
            end
        end
        if (inv_found_s) begin
            victim_s = inv_way_s;
        end else begin
            victim_s = rr_cur_s;
        end
    end

    // Hit line read-out and the line image after a byte-merged write.
    always_comb begin
        hit_line_s    = data_r[hit_way_s][idx_s];
        merged_line_s = hit_line_s;
        merged_line_s[word_s*WORD_W +: WORD_W] =
            merge_bytes(hit_line_s[word_s*WORD_W +: WORD_W], bus.mem_wdata, bus.mem_byte_enable);
    end

    generate
        if (WAYS > 1) begin : g_rr
            logic [WAY_W-1:0] rr_r [SETS];

            // Round-robin pointer per set; it advances only on a fill into a set with no invalid way.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < SETS; s++) begin
                        rr_r[s] <= {WAY_W{1'b0}};
                    end
                end else if (fill_en_s && victim_rr_r) begin
                    rr_r[idx_s] <= rr_r[idx_s] + WAY_W'(1);
                end
            end

            assign rr_cur_s = rr_r[idx_s];
        end else begin : g_no_rr
            assign rr_cur_s = {WAY_W{1'b0}};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and bus outputs; every output is zero outside the state that drives it.
    always_comb begin
        state_nx_s       = state_r;
        bus.mem_resp     = 1'b0;
        bus.mem_rdata    = {WORD_W{1'b0}};
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = {ADDR_W{1'b0}};
        bus.pmem_wdata   = {LINE_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    state_nx_s = CHECK;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CHECK: begin
                if (hit_s) begin
                    bus.mem_resp = 1'b1;
                    if (is_write_s) begin
                        bus.mem_rdata = {WORD_W{1'b0}};
                    end else begin
                        bus.mem_rdata = hit_line_s[word_s*WORD_W +: WORD_W];
                    end
                    state_nx_s = IDLE;
                end else if (valid_r[idx_s][victim_s] && dirty_r[idx_s][victim_s]) begin
                    state_nx_s = WB;
                end else begin
                    state_nx_s = ALLOC;
                end
            end
            WB: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_r[victim_r][idx_s], idx_s, {OFF{1'b0}}};
                bus.pmem_wdata   = data_r[victim_r][idx_s];
                if (bus.pmem_resp) begin
                    state_nx_s = ALLOC;
                end else begin
                    state_nx_s = WB;
                end
            end
            ALLOC: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {tag_s, idx_s, {OFF{1'b0}}};
                if (bus.pmem_resp) begin
                    state_nx_s = CHECK;
                end else begin
                    state_nx_s = ALLOC;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Latch the victim on a miss so that WB and ALLOC address the same way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            victim_r    <= {WAY_W{1'b0}};
            victim_rr_r <= 1'b0;
        end else if ((state_r == CHECK) && !hit_s) begin
            victim_r    <= victim_s;
            victim_rr_r <= ~inv_found_s;
        end
    end

    // Valid/dirty bookkeeping: a fill installs a clean line and a write hit marks its way dirty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= {WAYS{1'b0}};
                dirty_r[s] <= {WAYS{1'b0}};
            end
        end else if (fill_en_s) begin
            valid_r[idx_s][victim_r] <= 1'b1;
            dirty_r[idx_s][victim_r] <= 1'b0;
        end else if (hit_wr_en_s) begin
            dirty_r[idx_s][hit_way_s] <= 1'b1;
        end
    end

    // Data and tag storage, which is not reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (fill_en_s) begin
            data_r[victim_r][idx_s] <= bus.pmem_rdata;
            tag_r[victim_r][idx_s]  <= tag_s;
        end else if (hit_wr_en_s) begin
            data_r[hit_way_s][idx_s] <= merged_line_s;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic first_check_r;

    // Marks the first CHECK cycle of an access so that the post-fill CHECK is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_check_r <= 1'b0;
        end else begin
            first_check_r <= (state_r == IDLE) && req_s;
        end
    end

    // Saturating hit/miss counters, updated once per access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else if ((state_r == CHECK) && first_check_r) begin
            if (hit_s) begin
                if (hit_count != 32'hFFFF_FFFF) begin
                    hit_count <= hit_count + 32'd1;
                end
            end else begin
                if (miss_count != 32'hFFFF_FFFF) begin
                    miss_count <= miss_count + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_wb_assoc.sv
// Directed, table-driven bench for cache_wb_assoc in its default configuration
// (16-bit word, 128-bit line, 8 sets, 2 ways).
// Memory model: each word of an untouched line holds its own byte address, and
// line 0x0040 is preloaded with a distinct pattern. Write-backs update the model.
module tb_cache_wb_assoc;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   exp_hits = 0;
    int   exp_misses = 0;

    always #5 clk = ~clk;

    cache_wb_assoc_if #(.ADDR_W(16), .WORD_W(16), .LINE_W(128)) bus ();

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    cache_wb_assoc #(.ADDR_W(16), .WORD_W(16), .LINE_W(128), .SETS(8), .WAYS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    typedef struct {
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [1:0]   be;
        logic [15:0]  wdata;
        logic         exp_wb;
        logic [15:0]  exp_wb_addr;
        logic [127:0] exp_wb_data;
        logic         exp_fill;
        logic [15:0]  exp_fill_addr;
        logic [15:0]  exp_rdata;
        int           exp_lat;
    } vec_t;

    vec_t         vecs [16];
    logic [127:0] pmem_model [logic [15:0]];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                                input logic [1:0] be, input logic [15:0] wdata,
                                input logic exp_wb, input logic [15:0] wba, input logic [127:0] wbd,
                                input logic exp_fill, input logic [15:0] fa,
                                input logic [15:0] rdata, input int lat);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.be = be; v.wdata = wdata;
        v.exp_wb = exp_wb; v.exp_wb_addr = wba; v.exp_wb_data = wbd;
        v.exp_fill = exp_fill; v.exp_fill_addr = fa; v.exp_rdata = rdata; v.exp_lat = lat;
        return v;
    endfunction

    function automatic logic [127:0] line_of(input logic [15:0] a);
        logic [127:0] l;
        if (pmem_model.exists(a)) begin
            l = pmem_model[a];
        end else begin
            for (int i = 0; i < 8; i++) begin
                l[i*16 +: 16] = a + 16'(2 * i);
            end
        end
        return l;
    endfunction

    task automatic chk(input string name, input int row, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
        end
    endtask

    // Runs one CPU access, acting as a one-cycle memory, and compares the result with the vector.
    task automatic do_row(input int row, input vec_t v);
        int           lat;
        logic         got_resp;
        logic         wb_seen;
        logic         fill_seen;
        logic         order_ok;
        logic         excl_ok;
        logic [15:0]  wb_addr;
        logic [15:0]  fill_addr;
        logic [15:0]  rdata;
        logic [127:0] wb_data;
        lat = 0; got_resp = 1'b0; wb_seen = 1'b0; fill_seen = 1'b0;
        order_ok = 1'b1; excl_ok = 1'b1;
        wb_addr = 16'h0; fill_addr = 16'h0; rdata = 16'h0; wb_data = 128'h0;
        @(posedge clk); #1;
        bus.mem_read = v.rd; bus.mem_write = v.wr; bus.mem_address = v.addr;
        bus.mem_byte_enable = v.be; bus.mem_wdata = v.wdata;
        while (!got_resp && lat < 40) begin
            @(negedge clk);
            lat++;
            if ((2'(bus.mem_resp) + 2'(bus.pmem_read) + 2'(bus.pmem_write)) > 2'd1) excl_ok = 1'b0;
            if (bus.pmem_write) begin
                if (fill_seen) order_ok = 1'b0;
                if (!wb_seen) begin
                    wb_seen = 1'b1; wb_addr = bus.pmem_address; wb_data = bus.pmem_wdata;
                end
                pmem_model[bus.pmem_address] = bus.pmem_wdata;
            end
            if (bus.pmem_read) begin
                fill_seen = 1'b1; fill_addr = bus.pmem_address;
                bus.pmem_rdata = line_of(bus.pmem_address);
            end
            bus.pmem_resp = bus.pmem_read | bus.pmem_write;
            if (bus.mem_resp) begin
                got_resp = 1'b1; rdata = bus.mem_rdata;
            end
        end
        @(posedge clk); #1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.pmem_resp = 1'b0;
        chk("resp_seen", row, 128'(got_resp), 128'(1'b1));
        chk("latency", row, 128'(lat), 128'(v.exp_lat));
        chk("excl", row, 128'(excl_ok), 128'(1'b1));
        chk("wb_seen", row, 128'(wb_seen), 128'(v.exp_wb));
        chk("fill_seen", row, 128'(fill_seen), 128'(v.exp_fill));
        if (v.exp_wb) begin
            chk("wb_addr", row, 128'(wb_addr), 128'(v.exp_wb_addr));
            chk("wb_data", row, wb_data, v.exp_wb_data);
            chk("wb_order", row, 128'(order_ok), 128'(1'b1));
        end
        if (v.exp_fill) begin
            chk("fill_addr", row, 128'(fill_addr), 128'(v.exp_fill_addr));
            exp_misses++;
        end else begin
            exp_hits++;
        end
        if (v.rd) begin
            chk("rdata", row, 128'(rdata), 128'(v.exp_rdata));
        end
    endtask

    initial begin
        vecs[0]  = mk(1'b1, 1'b0, 16'h0042, 2'b00, 16'h0000, 1'b0, 16'h0, 128'h0, 1'b1, 16'h0040, 16'hBEEF, 4);
        vecs[1]  = mk(1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000, 1'b0, 16'h0, 128'h0, 1'b0, 16'h0000, 16'h1234, 2);
        vecs[2]  = mk(1'b0, 1'b1, 16'h0044, 2'b01, 16'h00AA, 1'b0, 16'h0, 128'h0, 1'b0, 16'h0000, 16'h0000, 2);
        vecs[3]  = mk(1'b1, 1'b0, 16'h0044, 2'b00, 16'h0000, 1'b0, 16'h0, 128'h0, 1'b0, 16'h0000, 16'h12AA, 2);
        vecs[4]  = mk(1'b0, 1'b1, 16'h0046, 2'b10, 16'hCD00, 1'b0, 16'h0, 128'h0, 1'b0, 16'h0000, 16'h0000, 2);
        vecs[5]  = mk(1'b1, 1'b0, 16'h0146, 2'b00, 16'h0000, 1'b0, 16'h0, 128'h0, 1'b1, 16'h0140, 16'h0146, 4);
        vecs[6]  = mk(1'b1, 1'b0, 16'h0242, 2'b00, 16'h0000, 1'b1, 16'h0040,
                      128'h7777_6666_5555_4444_CD33_12AA_BEEF_1234, 1'b1, 16'h0240, 16'h0242, 5);
        vecs[7]  = mk(1'b1, 1'b0, 16'h0140, 2'b00, 16'h0000, 1'b0, 16'h0, 128'h0, 1'b0, 16'h0000, 16'h0140, 2);
        vecs[8]  = mk(1'b0, 1'b1, 16'h0148, 2'b11, 16'h5A5A, 1'b0, 16'h0, 128'h0, 1'b0, 16'h0000, 16'h0000, 2);
        vecs[9]  = mk(1'b1, 1'b0, 16'h0044, 2'b00, 16'h0000, 1'b1, 16'h0140,
                      128'h014E_014C_014A_5A5A_0146_0144_0142_0140, 1'b1, 16'h0040, 16'h12AA, 5);
        vecs[10] = mk(1'b1, 1'b0, 16'h0242, 2'b00, 16'h0000, 1'b0, 16'h0, 128'h0, 1'b0, 16'h0000, 16'h0242, 2);
        vecs[11] = mk(1'b1, 1'b0, 16'h0A30, 2'b00, 16'h0000, 1'b0, 16'h0, 128'h0, 1'b1, 16'h0A30, 16'h0A30, 4);
        vecs[12] = mk(1'b1, 1'b1, 16'h0A32, 2'b11, 16'hFFFF, 1'b0, 16'h0, 128'h0, 1'b0, 16'h0000, 16'h0A32, 2);
        vecs[13] = mk(1'b1, 1'b0, 16'h0A32, 2'b00, 16'h0000, 1'b0, 16'h0, 128'h0, 1'b0, 16'h0000, 16'h0A32, 2);
        vecs[14] = mk(1'b0, 1'b1, 16'h0C50, 2'b01, 16'h0077, 1'b0, 16'h0, 128'h0, 1'b1, 16'h0C50, 16'h0000, 4);
        vecs[15] = mk(1'b1, 1'b0, 16'h0C50, 2'b00, 16'h0000, 1'b0, 16'h0, 128'h0, 1'b0, 16'h0000, 16'h0C77, 2);
        pmem_model[16'h0040] = 128'h7777_6666_5555_4444_3333_1234_BEEF_1234;

        rst_n = 1'b0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_byte_enable = 2'b00;
        bus.mem_address = 16'h0; bus.mem_wdata = 16'h0;
        bus.pmem_resp = 1'b0; bus.pmem_rdata = 128'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_resp", -1, 128'(bus.mem_resp), 128'(1'b0));
        chk("rst_mem_rdata", -1, 128'(bus.mem_rdata), 128'(16'h0));
        chk("rst_pmem_read", -1, 128'(bus.pmem_read), 128'(1'b0));
        chk("rst_pmem_write", -1, 128'(bus.pmem_write), 128'(1'b0));
        chk("rst_pmem_address", -1, 128'(bus.pmem_address), 128'(16'h0));
        chk("rst_pmem_wdata", -1, bus.pmem_wdata, 128'h0);
`ifdef CACHE_PERF_CNT_EN
        chk("rst_hit_count", -1, 128'(hit_count), 128'(32'd0));
        chk("rst_miss_count", -1, 128'(miss_count), 128'(32'd0));
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_row(i, vecs[i]);
        end

        // A stray pmem_resp while idle must not start or disturb anything.
        @(posedge clk); #1;
        bus.pmem_resp = 1'b1; bus.pmem_rdata = {8{16'hDEAD}};
        @(negedge clk);
        chk("stray_pmem_read", 16, 128'(bus.pmem_read), 128'(1'b0));
        chk("stray_pmem_write", 16, 128'(bus.pmem_write), 128'(1'b0));
        chk("stray_mem_resp", 16, 128'(bus.mem_resp), 128'(1'b0));
        @(posedge clk); #1;
        bus.pmem_resp = 1'b0;
        do_row(16, mk(1'b1, 1'b0, 16'h0C50, 2'b00, 16'h0000, 1'b0, 16'h0, 128'h0, 1'b0, 16'h0000, 16'h0C77, 2));

`ifdef CACHE_PERF_CNT_EN
        chk("hit_count", 17, 128'(hit_count), 128'(exp_hits));
        chk("miss_count", 17, 128'(miss_count), 128'(exp_misses));
`endif

        // Reset in the middle of a fill: the request must drop at once and nothing may stay cached.
        @(posedge clk); #1;
        bus.mem_read = 1'b1; bus.mem_address = 16'h0E60;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.pmem_read) break;
        end
        chk("alloc_pmem_read", 18, 128'(bus.pmem_read), 128'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("rst_alloc_pmem_read", 18, 128'(bus.pmem_read), 128'(1'b0));
        chk("rst_alloc_pmem_write", 18, 128'(bus.pmem_write), 128'(1'b0));
        chk("rst_alloc_pmem_address", 18, 128'(bus.pmem_address), 128'(16'h0));
        chk("rst_alloc_mem_resp", 18, 128'(bus.mem_resp), 128'(1'b0));
        bus.mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`ifdef CACHE_PERF_CNT_EN
        chk("rst2_hit_count", 18, 128'(hit_count), 128'(32'd0));
        chk("rst2_miss_count", 18, 128'(miss_count), 128'(32'd0));
`endif
        do_row(19, mk(1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000, 1'b0, 16'h0, 128'h0, 1'b1, 16'h0040, 16'h1234, 4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
